// File: rtl/bcd_digit_mul_seq.sv
// Sequential BCD multiplier: DIGITS-digit packed-BCD operand times one BCD digit, LSB digit first.
// Optional input validation is enabled by defining BCDM_CHECK_EN.
module bcd_digit_mul_seq #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic                    start,
    input  logic [4*DIGITS-1:0]     a,
    input  logic [3:0]              m,
    output logic                    busy,
    output logic                    done,
    output logic [4*(DIGITS+1)-1:0] p,
    output logic                    err
);

    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e                    state_q, state_d;
    logic [4*DIGITS-1:0]       a_q, a_d;
    logic [3:0]                m_q, m_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [4:0]                carry_q, carry_d;
    logic [4*DIGITS-1:0]       acc_q, acc_d;
    logic [4*(DIGITS+1)-1:0]   p_q, p_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;
    logic                      bad_q, bad_d;
    logic                      bad_in;
    logic [3:0]                dig;
    logic [8:0]                t;

`ifdef BCDM_CHECK_EN
    function automatic logic has_bad(input logic [4*DIGITS-1:0] v, input logic [3:0] d);
        logic b;
        b = (d > 4'd9);
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (v[4*i +: 4] > 4'd9) b = 1'b1;
        end
        return b;
    endfunction
`endif

    always_comb begin
`ifdef BCDM_CHECK_EN
        bad_in = has_bad(a, m);
`else
        bad_in = 1'b0;
`endif
        state_d = state_q;
        a_d     = a_q;
        m_d     = m_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        acc_d   = acc_q;
        p_d     = p_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        bad_d   = bad_q;
        dig     = a_q[4*idx_q +: 4];
        t       = 9'(dig) * 9'(m_q) + 9'(carry_q);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    m_d     = m;
                    idx_d   = '0;
                    carry_d = '0;
                    acc_d   = '0;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    bad_d   = bad_in;
                    // Invalid operands skip the digit loop entirely.
                    state_d = bad_in ? StFin : StRun;
                end
            end
            StRun: begin
                acc_d[4*idx_q +: 4] = 4'(t % 9'd10);
                carry_d             = 5'(t / 9'd10);
                idx_d               = idx_q + 1'b1;
                if (idx_q == LAST) state_d = StFin;
            end
            StFin: begin
                p_d     = bad_q ? '0 : {4'(carry_q % 5'd10), acc_q};
                err_d   = bad_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= StIdle;
            a_q     <= '0;
            m_q     <= '0;
            idx_q   <= '0;
            carry_q <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            m_q     <= m_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            bad_q   <= bad_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign p    = p_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_digit_mul_seq.sv
// Scoreboard bench for bcd_digit_mul_seq: directed starts push expected products,
// a negedge monitor pops and checks them whenever done pulses.
module tb_bcd_digit_mul_seq;

    localparam int unsigned DIGITS = 4;
    localparam int LAT = DIGITS + 2;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [3:0]  m = '0;
    logic        busy, done, err;
    logic [19:0] p;

    typedef struct {
        logic [19:0] p;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t got;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   dones = 0;
    int   pushes = 0;

    bcd_digit_mul_seq #(.DIGITS(DIGITS)) dut (
        .clk  (clk),
        .rst_b(rst_b),
        .start(start),
        .a    (a),
        .m    (m),
        .busy (busy),
        .done (done),
        .p    (p),
        .err  (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_b && done === 1'b1) begin
            dones++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got p=%h at cycle %0d want no done", p, cyc);
            end else begin
                got = sb.pop_front();
                check("p", 32'(p), 32'(got.p));
                check("err", 32'(err), 32'(got.err));
                check("done_cycle", 32'(cyc), 32'(got.cyc));
            end
        end
    end

    // Called at a negedge; start is sampled at the next posedge (edge k).
    task automatic go(input logic [15:0] av, input logic [3:0] mv, input logic [19:0] ep,
                      input logic ee, input int lat, input bit push);
        exp_t e;
        start = 1'b1;
        a     = av;
        m     = mv;
        if (push) begin
            e.p   = ep;
            e.err = ee;
            e.cyc = cyc + lat;
            sb.push_back(e);
            pushes++;
        end
        @(negedge clk);
        start = 1'b0;
        a     = 16'hfafa;
        m     = 4'hf;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done want done within 40 cycles", name);
        end else begin
            check({name, "_busy_at_done"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_p", 32'(p), 32'd0);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);

        go(16'h1234, 4'd5, 20'h06170, 1'b0, LAT, 1'b1);
        check("busy_after_start", 32'(busy), 32'd1);
        wait_done("t1234x5");

        @(negedge clk);
        go(16'h9999, 4'd9, 20'h89991, 1'b0, LAT, 1'b1);
        wait_done("t9999x9");
        go(16'h0000, 4'd7, 20'h00000, 1'b0, LAT, 1'b1);
        check("p_holds_prev", 32'(p), 32'h89991);
        wait_done("b2b_zero");

        @(negedge clk);
        go(16'h4321, 4'd2, 20'h08642, 1'b0, LAT, 1'b1);
        @(negedge clk);
        go(16'h1111, 4'd9, 20'h0, 1'b0, 0, 1'b0);
        check("busy_ignored_start", 32'(busy), 32'd1);
        wait_done("t4321x2");

        @(negedge clk);
        go(16'h5555, 4'd3, 20'h0, 1'b0, 0, 1'b0);
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_p", 32'(p), 32'd0);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        repeat (8) @(negedge clk);
        go(16'h0005, 4'd5, 20'h00025, 1'b0, LAT, 1'b1);
        wait_done("t5x5");

        @(negedge clk);
        go(16'h9876, 4'd0, 20'h00000, 1'b0, LAT, 1'b1);
        wait_done("m_zero");
        go(16'h0999, 4'd8, 20'h07992, 1'b0, LAT, 1'b1);
        wait_done("t999x8");
        go(16'h1111, 4'd9, 20'h09999, 1'b0, LAT, 1'b1);
        wait_done("t1111x9");

`ifdef BCDM_CHECK_EN
        @(negedge clk);
        go(16'h12a4, 4'd3, 20'h00000, 1'b1, 2, 1'b1);
        wait_done("bad_nibble");
        check("err_held", 32'(err), 32'd1);
        @(negedge clk);
        check("err_sticky", 32'(err), 32'd1);
        go(16'h0001, 4'd1, 20'h00001, 1'b0, LAT, 1'b1);
        check("err_cleared", 32'(err), 32'd0);
        wait_done("after_bad");
`endif

        repeat (10) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("done_count", 32'(dones), 32'(pushes));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
